// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, request credits, in-order instruction queue, redirect flush.
// Optional FETCH_PREDECODE_EN adds a registered immediate-format code (dec_type_o) per queue entry.
`ifdef FETCH_PREDECODE_EN
`ifndef RTYPE
`define RTYPE 3'd0
`endif
`ifndef ITYPE
`define ITYPE 3'd1
`endif
`ifndef STYPE
`define STYPE 3'd2
`endif
`ifndef BTYPE
`define BTYPE 3'd3
`endif
`ifndef UTYPE
`define UTYPE 3'd4
`endif
`ifndef JTYPE
`define JTYPE 3'd5
`endif
`endif

module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_instr_o,
    output logic [31:0] dec_pc_o
`ifdef FETCH_PREDECODE_EN
    ,
    output logic [2:0]  dec_type_o
`endif
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [AW-1:0] AONE = AW'(1);
    localparam logic [CW:0]   QD_X = (CW+1)'(QUEUE_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, ph_q, ph_d, pt_q, pt_d;
    logic [31:0]   instr_mem_q [QUEUE_DEPTH];
    logic [31:0]   pc_mem_q    [QUEUE_DEPTH];
    logic [31:0]   req_pc_q    [QUEUE_DEPTH];
`ifdef FETCH_PREDECODE_EN
    logic [2:0]    type_mem_q  [QUEUE_DEPTH];

    function automatic logic [2:0] imm_type(input logic [6:0] op);
        case (op)
            7'b0110011:                                     imm_type = `RTYPE;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm_type = `ITYPE;
            7'b0100011:                                     imm_type = `STYPE;
            7'b1100011:                                     imm_type = `BTYPE;
            7'b0110111, 7'b0010111:                         imm_type = `UTYPE;
            7'b1101111:                                     imm_type = `JTYPE;
            default:                                        imm_type = `RTYPE;
        endcase
    endfunction
`endif

    logic [CW:0] inflight;
    logic        req_fire, rsp_acc, push, pop, drop_dec;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Credits cover both queued entries and in-flight requests, so a response always has a slot.
    assign inflight         = {1'b0, out_q} + {1'b0, count_q};
    assign imem_req_valid_o = rst_ni && !redirect_i && (inflight < QD_X);
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_acc          = imem_rsp_valid_i && (out_q != '0);
    assign push             = rsp_acc && !redirect_i && (drop_q == '0);
    assign drop_dec         = rsp_acc && !redirect_i && (drop_q != '0);
    assign pop              = dec_valid_o && dec_ready_i && !redirect_i;

    assign dec_valid_o = (count_q != '0);
    assign dec_instr_o = instr_mem_q[head_q];
    assign dec_pc_o    = pc_mem_q[head_q];
`ifdef FETCH_PREDECODE_EN
    assign dec_type_o  = type_mem_q[head_q];
`endif

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        out_d   = out_q;
        drop_d  = drop_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ph_d    = ph_q;
        pt_d    = pt_q;
        if (req_fire) begin
            out_d = out_d + ONE;
            pt_d  = pt_q + AONE;
        end
        if (rsp_acc) begin
            out_d = out_d - ONE;
            ph_d  = ph_q + AONE;
        end
        if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the wrong path.
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            drop_d  = out_d;
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (drop_dec) drop_d = drop_q - ONE;
            if (push) tail_d = tail_q + AONE;
            if (pop) head_d = head_q + AONE;
            if (push && !pop)      count_d = count_q + ONE;
            else if (pop && !push) count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            ph_q    <= '0;
            pt_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
                req_pc_q[i]    <= '0;
`ifdef FETCH_PREDECODE_EN
                type_mem_q[i]  <= '0;
`endif
            end
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ph_q    <= ph_d;
            pt_q    <= pt_d;
            if (req_fire) req_pc_q[pt_q] <= pc_q;
            if (push) begin
                instr_mem_q[tail_q] <= imem_rsp_data_i;
                pc_mem_q[tail_q]    <= req_pc_q[ph_q];
`ifdef FETCH_PREDECODE_EN
                type_mem_q[tail_q]  <= imm_type(imem_rsp_data_i[6:0]);
`endif
            end
        end
    end
endmodule
